// File: rtl/seq_gen_if.sv
// Request/status bundle between a sequence-source controller and seq_gen.
// The master side drives the transfer request; the slave side is the serialiser.
interface seq_gen_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] pattern;
   logic [CNT_W-1:0] repeat_n;
   logic             abort;
   logic             outp;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic [5:0]       bit_idx;

   modport master (
      output start, mode, pattern, repeat_n, abort,
      input  outp, out_valid, busy, done, bit_idx
   );

   modport slave (
      input  start, mode, pattern, repeat_n, abort,
      output outp, out_valid, busy, done, bit_idx
   );
endinterface

// File: rtl/seq_gen.sv
// Serial test-sequence transmitter: emits a latched pattern LSB-first or a
// 16-bit Fibonacci LFSR stream, one bit per clock, with repeat passes and abort.
module seq_gen #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic     clk,
   input  logic     rst,
   seq_gen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [5:0]  LAST_IDX     = 6'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] pattern_reg, pattern_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic             mode_reg, mode_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [15:0]      lfsr_reg, lfsr_next;
   logic [5:0]       bit_idx_reg, bit_idx_next;
   logic             outp_reg, outp_next;
   logic             valid_reg, valid_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic [15:0]      seed;
   logic [15:0]      lfsr_step;

   // An all-zero seed would lock the LFSR, so it is substituted.
   assign seed      = (bus.pattern[15:0] == 16'h0000) ? DEFAULT_SEED : bus.pattern[15:0];
   assign lfsr_step = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         pattern_reg <= '0;
         shift_reg   <= '0;
         mode_reg    <= 1'b0;
         cnt_reg     <= '0;
         lfsr_reg    <= '0;
         bit_idx_reg <= '0;
         outp_reg    <= 1'b0;
         valid_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pattern_reg <= pattern_next;
         shift_reg   <= shift_next;
         mode_reg    <= mode_next;
         cnt_reg     <= cnt_next;
         lfsr_reg    <= lfsr_next;
         bit_idx_reg <= bit_idx_next;
         outp_reg    <= outp_next;
         valid_reg   <= valid_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pattern_next = pattern_reg;
      shift_next   = shift_reg;
      mode_next    = mode_reg;
      cnt_next     = cnt_reg;
      lfsr_next    = lfsr_reg;
      bit_idx_next = bit_idx_reg;
      outp_next    = 1'b0;
      valid_next   = 1'b0;
      done_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_next   = SHIFT;
               pattern_next = bus.pattern;
               shift_next   = bus.pattern;
               mode_next    = bus.mode;
               cnt_next     = bus.repeat_n;
               lfsr_next    = seed;
               bit_idx_next = '0;
               valid_next   = 1'b1;
               outp_next    = bus.mode ? seed[0] : bus.pattern[0];
            end
         end

         SHIFT: begin
            if (bus.abort) begin
               state_next   = IDLE;
               bit_idx_next = '0;
            end else begin
               valid_next = 1'b1;
               // The LFSR free-runs across pass boundaries; only a new start reseeds it.
               if (mode_reg) lfsr_next = lfsr_step;
               if (bit_idx_reg == LAST_IDX) begin
                  if (cnt_reg != '0) begin
                     cnt_next     = cnt_reg - CNT_W'(1);
                     bit_idx_next = '0;
                     shift_next   = pattern_reg;
                     outp_next    = mode_reg ? lfsr_step[0] : pattern_reg[0];
                  end else begin
                     state_next   = DONE;
                     valid_next   = 1'b0;
                     done_next    = 1'b1;
                     bit_idx_next = '0;
                  end
               end else begin
                  bit_idx_next = bit_idx_reg + 6'd1;
                  shift_next   = shift_reg >> 1;
                  outp_next    = mode_reg ? lfsr_step[0] : shift_reg[1];
               end
            end
         end

         DONE: state_next = IDLE;

         default: state_next = IDLE;
      endcase
   end

   always_comb busy_next = (state_next != IDLE);

   assign bus.outp      = outp_reg;
   assign bus.out_valid = valid_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.bit_idx   = bit_idx_reg;
endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: table of directed transfers, hand-written corner cases
// and random transfers, all checked against a queue-based stream model.
module tb_seq_gen;
   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   seq_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pat;
      logic        mode;
      int          rep;
      int          abort_at;
      logic [15:0] exp_word;
      logic [15:0] exp_mask;
      int          exp_len;
      int          exp_done;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
      return {^(l & 16'h002D), l[15:1]};
   endfunction

   // Runs one transfer starting at the next edge and checks every cycle until back in IDLE.
   task automatic run_transfer(input logic [WIDTH-1:0] pat, input logic mode, input int rep,
                               input int abort_at, output logic [15:0] got_word,
                               output int got_len, output int got_done);
      bit          exp_q[$];
      logic [15:0] l;
      int          nb;
      bit          aborted;
      l = (pat[15:0] == 16'h0000) ? 16'hACE1 : pat[15:0];
      for (int p = 0; p <= rep; p++) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (mode) begin
               exp_q.push_back(l[0]);
               l = lfsr_adv(l);
            end else begin
               exp_q.push_back(pat[k]);
            end
         end
      end
      aborted  = (abort_at >= 0) && (abort_at < exp_q.size());
      nb       = aborted ? abort_at + 1 : exp_q.size();
      got_word = '0;
      got_len  = 0;
      got_done = 0;

      @(negedge clk);
      bus.start    = 1'b1;
      bus.abort    = 1'b0;
      bus.mode     = mode;
      bus.pattern  = pat;
      bus.repeat_n = CNT_W'(rep);
      for (int c = 0; c < nb + 2; c++) begin
         @(negedge clk);
         bus.pattern  = WIDTH'($urandom);
         bus.mode     = 1'($urandom);
         bus.repeat_n = CNT_W'($urandom);
         bus.abort    = aborted && (c == abort_at);
         if (!aborted && c == nb) bus.abort = 1'($urandom_range(0, 1));
         bus.start = (c < nb || (c == nb && !aborted)) ? 1'($urandom_range(0, 1)) : 1'b0;

         if (c < nb) begin
            check($sformatf("outp c%0d", c), 64'(bus.outp), 64'(exp_q[c]));
            check($sformatf("valid c%0d", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("busy c%0d", c), 64'(bus.busy), 64'd1);
            check($sformatf("done c%0d", c), 64'(bus.done), 64'd0);
            check($sformatf("bit_idx c%0d", c), 64'(bus.bit_idx), 64'(c % WIDTH));
            if (c < 16) got_word[c] = bus.outp;
         end else if (c == nb && !aborted) begin
            check("done pulse", 64'(bus.done), 64'd1);
            check("done valid", 64'(bus.out_valid), 64'd0);
            check("done outp", 64'(bus.outp), 64'd0);
            check("done busy", 64'(bus.busy), 64'd1);
         end else begin
            check($sformatf("idle done c%0d", c), 64'(bus.done), 64'd0);
            check($sformatf("idle valid c%0d", c), 64'(bus.out_valid), 64'd0);
            check($sformatf("idle outp c%0d", c), 64'(bus.outp), 64'd0);
            check($sformatf("idle busy c%0d", c), 64'(bus.busy), 64'd0);
         end
         if (bus.out_valid === 1'b1) got_len++;
         if (bus.done === 1'b1) got_done++;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      $display("[TB] xfer pat=%h mode=%0d rep=%0d abort_at=%0d valid_cycles=%0d done_pulses=%0d",
               pat, mode, rep, abort_at, got_len, got_done);
   endtask

   initial begin
      vec_t        vecs[6];
      logic [15:0] w;
      int          len;
      int          dn;
      logic [15:0] rp;
      logic        rm;
      int          rr;
      int          ab;

      vecs[0] = '{16'h5772, 1'b0, 0, -1, 16'h5772, 16'hFFFF, 16, 1};
      vecs[1] = '{16'h0000, 1'b1, 0, -1, 16'h0001, 16'h0007, 16, 1};
      vecs[2] = '{16'hFFFF, 1'b0, 2, -1, 16'hFFFF, 16'hFFFF, 48, 1};
      vecs[3] = '{16'hA5C3, 1'b0, 0,  5, 16'h0003, 16'h003F,  6, 0};
      vecs[4] = '{16'h1234, 1'b0, 1, 31, 16'h1234, 16'hFFFF, 32, 0};
      vecs[5] = '{16'h0001, 1'b1, 1, -1, 16'h0001, 16'h0007, 32, 1};

      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.mode     = 1'b0;
      bus.pattern  = '0;
      bus.repeat_n = '0;

      #12;
      check("reset outp", 64'(bus.outp), 64'd0);
      check("reset valid", 64'(bus.out_valid), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset bit_idx", 64'(bus.bit_idx), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_transfer(WIDTH'(vecs[i].pat), vecs[i].mode, vecs[i].rep, vecs[i].abort_at, w, len, dn);
         check($sformatf("tbl%0d word", i), 64'(w & vecs[i].exp_mask), 64'(vecs[i].exp_word));
         check($sformatf("tbl%0d len", i), 64'(len), 64'(vecs[i].exp_len));
         check($sformatf("tbl%0d done", i), 64'(dn), 64'(vecs[i].exp_done));
      end

      // start together with abort in IDLE is not a request
      @(negedge clk);
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      bus.pattern = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("start+abort busy", 64'(bus.busy), 64'd0);
      check("start+abort valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check("start+abort busy2", 64'(bus.busy), 64'd0);
      $display("[TB] xfer start+abort in idle ignored");

      // asynchronous reset in the middle of a pass
      bus.start    = 1'b1;
      bus.mode     = 1'b0;
      bus.pattern  = 16'hFFFF;
      bus.repeat_n = '0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre-reset valid", 64'(bus.out_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("async rst outp", 64'(bus.outp), 64'd0);
      check("async rst valid", 64'(bus.out_valid), 64'd0);
      check("async rst busy", 64'(bus.busy), 64'd0);
      check("async rst done", 64'(bus.done), 64'd0);
      check("async rst bit_idx", 64'(bus.bit_idx), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post-reset busy", 64'(bus.busy), 64'd0);
      check("post-reset done", 64'(bus.done), 64'd0);
      $display("[TB] xfer async reset mid-pass");
      run_transfer(16'h5772, 1'b0, 0, -1, w, len, dn);
      check("post-reset word", 64'(w), 64'h5772);

      for (int i = 0; i < 30; i++) begin
         rp = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
         rm = 1'($urandom_range(0, 1));
         rr = int'($urandom_range(0, 2));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (rr + 1) * WIDTH - 1)) : -1;
         run_transfer(WIDTH'(rp), rm, rr, ab, w, len, dn);
         check($sformatf("rnd%0d done", i), 64'(dn), (ab < 0) ? 64'd1 : 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
